// File: rtl/fib_run_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fib_run_ctrl
// Sequencer for the Fibonacci datapath. A start command clears the core, then
// issues a programmed number of single-step pulses, one every clock_sel+1
// cycles. After the last step it captures the core value, flags 30-bit
// wrap-around seen during the run, and raises a sticky completion IRQ.
//
// Ports
//   wb_clk_i     in   system clock (only clock in this block)
//   reset        in   synchronous, active-high reset
//   start        in   run request, one-cycle pulse (acted on only in IDLE)
//   abort        in   stop the current run (returns to IDLE next edge)
//   irq_clr      in   clear done_irq
//   step_cnt     in   number of steps to run, latched at start
//   clock_sel    in   step interval minus one, latched at start
//   fib_val      in   core output, updates on the edge that samples fib_step
//   fib_clear    out  one-cycle pulse: reset core to F(0)=0
//   fib_step     out  one-cycle pulse: advance core by one term
//   busy         out  high while not IDLE
//   done_irq     out  sticky completion flag
//   ovf          out  sticky: core value wrapped during this run
//   result       out  fib_val captured after the last step
//   steps_done   out  number of fib_step pulses issued in this run
//   dbg_state_o  out  current FSM state encoding (debug visibility)
//
// Command semantics: there is no ready/acknowledge. start is sampled on every
// edge but only acted on in IDLE with abort low and step_cnt non-zero;
// anywhere else it is dropped silently. busy tells software whether a start
// will be taken. abort is sampled on every edge and only matters while busy.
// ---------------------------------------------------------------------------
module fib_run_ctrl #(
  parameter int CLOCK_WIDTH = 6,
  parameter int VAL_WIDTH   = 30,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   irq_clr,
  input  logic [CNT_WIDTH-1:0]   step_cnt,
  input  logic [CLOCK_WIDTH-1:0] clock_sel,
  input  logic [VAL_WIDTH-1:0]   fib_val,
  output logic                   fib_clear,
  output logic                   fib_step,
  output logic                   busy,
  output logic                   done_irq,
  output logic                   ovf,
  output logic [VAL_WIDTH-1:0]   result,
  output logic [CNT_WIDTH-1:0]   steps_done,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                 state_q,      state_d;
  logic [CNT_WIDTH-1:0]   target_q,     target_d;
  logic [CLOCK_WIDTH-1:0] interval_q,   interval_d;
  logic [CLOCK_WIDTH-1:0] div_q,        div_d;
  logic [VAL_WIDTH-1:0]   prev_val_q,   prev_val_d;
  logic [CNT_WIDTH-1:0]   steps_done_q, steps_done_d;
  logic                   ovf_q,        ovf_d;
  logic                   done_irq_q,   done_irq_d;
  logic [VAL_WIDTH-1:0]   result_q,     result_d;
  // Marks the cycle after a fib_step, when fib_val holds the new term.
  logic                   step_seen_q,  step_seen_d;

  logic                   clear_c;
  logic                   step_c;
  logic                   set_irq_c;
  logic [CNT_WIDTH-1:0]   steps_inc;

  assign steps_inc = steps_done_q + 1'b1;

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      state_q      <= S_IDLE;
      target_q     <= '0;
      interval_q   <= '0;
      div_q        <= '0;
      prev_val_q   <= '0;
      steps_done_q <= '0;
      ovf_q        <= 1'b0;
      done_irq_q   <= 1'b0;
      result_q     <= '0;
      step_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      interval_q   <= interval_d;
      div_q        <= div_d;
      prev_val_q   <= prev_val_d;
      steps_done_q <= steps_done_d;
      ovf_q        <= ovf_d;
      done_irq_q   <= done_irq_d;
      result_q     <= result_d;
      step_seen_q  <= step_seen_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    interval_d   = interval_q;
    div_d        = div_q;
    prev_val_d   = prev_val_q;
    steps_done_d = steps_done_q;
    ovf_d        = ovf_q;
    result_d     = result_q;
    clear_c      = 1'b0;
    step_c       = 1'b0;
    set_irq_c    = 1'b0;

    // Wrap detection: a Fibonacci sequence only ever grows, so the first
    // modular wrap always shows up as a decrease against the previous term.
    if (step_seen_q) begin
      if (fib_val < prev_val_q) begin
        ovf_d = 1'b1;
      end
      prev_val_d = fib_val;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort && (step_cnt != '0)) begin
          state_d    = S_CLEAR;
          target_d   = step_cnt;
          interval_d = clock_sel;
        end
      end

      S_CLEAR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          clear_c      = 1'b1;
          steps_done_d = '0;
          ovf_d        = 1'b0;
          prev_val_d   = '0;
          div_d        = interval_q;
          state_d      = S_RUN;
        end
      end

      S_RUN: begin
        if (abort) begin
          // Partial steps_done/ovf are kept for software to inspect.
          state_d = S_IDLE;
        end else if (div_q == '0) begin
          step_c       = 1'b1;
          steps_done_d = steps_inc;
          div_d        = interval_q;
          if (steps_inc == target_q) begin
            state_d = S_DRAIN;
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end

      S_DRAIN: begin
        // fib_val already reflects the last step here.
        state_d = S_IDLE;
        if (!abort) begin
          result_d  = fib_val;
          set_irq_c = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Completion wins over a coincident clear so no completion is lost.
    done_irq_d = done_irq_q;
    if (set_irq_c) begin
      done_irq_d = 1'b1;
    end else if (irq_clr) begin
      done_irq_d = 1'b0;
    end

    step_seen_d = step_c;
  end

  // Pulses are suppressed while reset is asserted so the core never sees a
  // step on the edge that returns this block to IDLE.
  assign fib_clear   = clear_c & ~reset;
  assign fib_step    = step_c & ~reset;
  assign busy        = (state_q != S_IDLE);
  assign done_irq    = done_irq_q;
  assign ovf         = ovf_q;
  assign result      = result_q;
  assign steps_done  = steps_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fib_run_ctrl.sv
`timescale 1ns/1ps
// Testbench for fib_run_ctrl. A small reference Fibonacci core is attached to
// the sequencer outputs. Cycle numbering inside each run: T0 is the cycle in
// which start is driven, T1 is the cycle after start is accepted (CLEAR).
module tb_fib_run_ctrl;

  localparam int CW = 6;
  localparam int VW = 30;
  localparam int NW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start;
  logic          abort;
  logic          irq_clr;
  logic [NW-1:0] step_cnt;
  logic [CW-1:0] clock_sel;
  logic [VW-1:0] fib_val;
  logic          fib_clear;
  logic          fib_step;
  logic          busy;
  logic          done_irq;
  logic          ovf;
  logic [VW-1:0] result;
  logic [NW-1:0] steps_done;
  logic [1:0]    dbg_state;

  fib_run_ctrl #(
    .CLOCK_WIDTH (CW),
    .VAL_WIDTH   (VW),
    .CNT_WIDTH   (NW)
  ) dut (
    .wb_clk_i    (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .irq_clr     (irq_clr),
    .step_cnt    (step_cnt),
    .clock_sel   (clock_sel),
    .fib_val     (fib_val),
    .fib_clear   (fib_clear),
    .fib_step    (fib_step),
    .busy        (busy),
    .done_irq    (done_irq),
    .ovf         (ovf),
    .result      (result),
    .steps_done  (steps_done),
    .dbg_state_o (dbg_state)
  );

  // ---------------- reference core ----------------
  logic [VW-1:0] core_a;
  logic [VW-1:0] core_b;
  always @(posedge clk) begin
    if (reset || fib_clear) begin
      core_a <= '0;
      core_b <= 30'd1;
    end else if (fib_step) begin
      core_a <= core_b;
      core_b <= core_a + core_b;
    end
  end
  assign fib_val = core_a;

  // ---------------- bookkeeping ----------------
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] step_mask;
  logic [127:0] clear_mask;
  int           done_cyc;
  int           ovf_cyc;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_irq();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
  endtask

  // Drives start in T0 and returns in T1; afterwards the config inputs are
  // scrambled to show the latched copies are used.
  task automatic start_run(input logic [NW-1:0] n, input logic [CW-1:0] sel);
    step_cnt  = n;
    clock_sel = sel;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    step_cnt  = NW'($urandom_range(0, 65535));
    clock_sel = CW'($urandom_range(0, 63));
  endtask

  // Records pulses per cycle starting at T1 until done_irq reads 1 or the
  // cycle budget runs out (done_cyc then stays -1).
  task automatic monitor(input int max_cyc);
    step_mask  = '0;
    clear_mask = '0;
    done_cyc   = -1;
    ovf_cyc    = -1;
    for (int cyc = 1; cyc < max_cyc; cyc++) begin
      step_mask[cyc[6:0]]  = fib_step;
      clear_mask[cyc[6:0]] = fib_clear;
      if (ovf && ovf_cyc < 0 && cyc >= 2) ovf_cyc = cyc;
      if (done_irq) begin
        done_cyc = cyc;
        break;
      end
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; irq_clr = 1'b0;
    step_cnt = '0; clock_sel = '0;
    repeat (3) tick();
    n_checks++;
    if ({busy, fib_step, fib_clear, done_irq, ovf} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {busy, fib_step, fib_clear, done_irq, ovf});
    end
    n_checks++;
    if (result !== 30'd0 || steps_done !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_regs: result=%0d steps_done=%0d expected 0/0", result, steps_done);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    start_run(16'd10, 6'd0);
    repeat (3) tick();                  // T4: RUN, step cycle
    n_checks++;
    if (busy !== 1'b1 || fib_step !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: busy=%b fib_step=%b expected 1/1", busy, fib_step);
    end
    reset = 1'b1;
    tick();                             // T5
    n_checks++;
    if ({busy, fib_step, fib_clear, done_irq, ovf} !== 5'b0 ||
        result !== 30'd0 || steps_done !== 16'd0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: busy=%b step=%b clr=%b irq=%b ovf=%b res=%0d sd=%0d st=%0d expected all 0",
               busy, fib_step, fib_clear, done_irq, ovf, result, steps_done, dbg_state);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || fib_step !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_idle: busy=%b fib_step=%b expected 0/0", busy, fib_step);
    end
  endtask

  task automatic test_basic();          // N=5, sel=0
    clear_irq();
    start_run(16'd5, 6'd0);
    monitor(40);
    n_checks++;
    if (clear_mask !== 128'h2) begin
      n_fail++;
      $display("FAIL basic_clear: got %h expected %h", clear_mask, 128'h2);
    end
    n_checks++;
    if (step_mask !== 128'h7C) begin
      n_fail++;
      $display("FAIL basic_steps: got %h expected %h", step_mask, 128'h7C);
    end
    n_checks++;
    if (done_cyc !== 8) begin
      n_fail++;
      $display("FAIL basic_done_cycle: got %0d expected 8", done_cyc);
    end
    n_checks++;
    if (result !== 30'd5 || ovf !== 1'b0 || steps_done !== 16'd5 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_final: result=%0d ovf=%b steps=%0d busy=%b expected 5/0/5/0",
               result, ovf, steps_done, busy);
    end
  endtask

  task automatic test_slow();           // N=3, sel=3: steps T5,T9,T13; DRAIN T14; irq visible T15
    clear_irq();
    start_run(16'd3, 6'd3);
    monitor(40);
    n_checks++;
    if (step_mask !== 128'h2220) begin
      n_fail++;
      $display("FAIL slow_steps: got %h expected %h", step_mask, 128'h2220);
    end
    n_checks++;
    if (done_cyc !== 15) begin
      n_fail++;
      $display("FAIL slow_done_cycle: got %0d expected 15", done_cyc);
    end
    n_checks++;
    if (result !== 30'd2 || steps_done !== 16'd3 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL slow_final: result=%0d steps=%0d ovf=%b expected 2/3/0", result, steps_done, ovf);
    end
  endtask

  task automatic test_wrap();           // N=50, sel=0; step 45 wraps in T46, ovf visible T48
    logic [127:0] exp_mask;
    exp_mask = ((128'd1 << 50) - 128'd1) << 2;
    clear_irq();
    start_run(16'd50, 6'd0);
    monitor(100);
    n_checks++;
    if (step_mask !== exp_mask) begin
      n_fail++;
      $display("FAIL wrap_steps: got %h expected %h", step_mask, exp_mask);
    end
    n_checks++;
    if (ovf !== 1'b1 || ovf_cyc !== 48) begin
      n_fail++;
      $display("FAIL wrap_ovf: ovf=%b first_cycle=%0d expected 1/48", ovf, ovf_cyc);
    end
    n_checks++;
    if (result !== 30'd775108961 || steps_done !== 16'd50 || done_cyc !== 53) begin
      n_fail++;
      $display("FAIL wrap_final: result=%0d steps=%0d done_cyc=%0d expected 775108961/50/53",
               result, steps_done, done_cyc);
    end
  endtask

  task automatic test_abort();          // N=10, sel=1: steps T3,T5; abort in T6
    int pulses;
    clear_irq();
    n_checks++;
    if (done_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_irq_cleared: got %b expected 0", done_irq);
    end
    start_run(16'd10, 6'd1);
    repeat (2) tick();                  // T3
    n_checks++;
    if (fib_step !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_step1: got %b expected 1", fib_step);
    end
    repeat (2) tick();                  // T5
    n_checks++;
    if (fib_step !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_step2: got %b expected 1", fib_step);
    end
    tick();                             // T6
    abort = 1'b1;
    tick();                             // T7
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || steps_done !== 16'd2 || done_irq !== 1'b0 || result !== 30'd775108961) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b steps=%0d irq=%b result=%0d expected 0/2/0/775108961",
               busy, steps_done, done_irq, result);
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (fib_step) pulses++;
      tick();
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL abort_no_pulses: got %0d expected 0", pulses);
    end
  endtask

  task automatic test_ignored_start();
    step_cnt = 16'd0; clock_sel = 6'd0; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || fib_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_count_start: busy=%b fib_clear=%b expected 0/0", busy, fib_clear);
    end
    step_cnt = 16'd4; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || fib_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_beats_start: busy=%b fib_clear=%b expected 0/0", busy, fib_clear);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || steps_done !== 16'd2 || result !== 30'd775108961) begin
      n_fail++;
      $display("FAIL idle_abort: busy=%b steps=%0d result=%0d expected 0/2/775108961",
               busy, steps_done, result);
    end
  endtask

  // N=4, sel=2 with start held high (and different config) for the whole run:
  // steps T4,T7,T10,T13; DRAIN T14; irq visible T15; no second CLEAR.
  task automatic test_restart_ignored();
    clear_irq();
    start_run(16'd4, 6'd2);
    step_cnt  = 16'd1;
    clock_sel = 6'd0;
    start     = 1'b1;
    monitor(40);
    start = 1'b0;
    n_checks++;
    if (step_mask !== 128'h2490 || clear_mask !== 128'h2) begin
      n_fail++;
      $display("FAIL restart_pulses: steps=%h clears=%h expected %h/%h",
               step_mask, clear_mask, 128'h2490, 128'h2);
    end
    n_checks++;
    if (done_cyc !== 15 || steps_done !== 16'd4 || result !== 30'd3) begin
      n_fail++;
      $display("FAIL restart_final: done_cyc=%0d steps=%0d result=%0d expected 15/4/3",
               done_cyc, steps_done, result);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_irq_clr();        // N=1, sel=0: step T2, DRAIN T3
    clear_irq();
    start_run(16'd1, 6'd0);
    repeat (2) tick();                  // T3
    n_checks++;
    if (dbg_state !== 2'd3) begin
      n_fail++;
      $display("FAIL irq_drain_state: got %0d expected 3", dbg_state);
    end
    irq_clr = 1'b1;
    tick();                             // T4
    irq_clr = 1'b0;
    n_checks++;
    if (done_irq !== 1'b1 || result !== 30'd1) begin
      n_fail++;
      $display("FAIL irq_set_wins: irq=%b result=%0d expected 1/1", done_irq, result);
    end
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    n_checks++;
    if (done_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_later_clear: got %b expected 0", done_irq);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_reset_mid_run();
    test_basic();
    test_slow();
    test_wrap();
    test_abort();
    test_ignored_start();
    test_restart_ignored();
    test_irq_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
